cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 202 ++++++++++++++++++++
 tb/tb_cache_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Control FSM for a write-back cache. It sequences the tag compare, an
// optional dirty-victim writeback and the line refill against a main memory
// whose block transfer takes MEM_LATENCY cycles. Then it returns a one-cycle
// completion pulse to the CPU.
//
// Parameters
//   MEM_LATENCY   main-memory cycles per block transfer (1..15)
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_b          in   synchronous reset, active-HIGH despite the name
//   cpu_req        in   CPU access request (only looked at in IDLE)
//   cpu_we         in   request type, 1 = write (captured with cpu_req)
//   hit            in   tag match for the current address
//   dirty_bit      in   dirty flag of the victim line
//   cpu_ready      out  one-cycle completion pulse
//   cache_we       out  cache line write enable
//   mem_in_select  out  memory address select, 1 = victim, 0 = CPU address
//   mem_we         out  main-memory write strobe
//   mem_re         out  main-memory read strobe
//   hit_cnt        out  (CACHE_CTRL_STATS_EN only) saturating hit count
//   miss_cnt       out  (CACHE_CTRL_STATS_EN only) saturating miss count
//
// Optional feature: define CACHE_CTRL_STATS_EN to add the hit/miss
// statistics counters and their output ports.
// ---------------------------------------------------------------------------
module cache_controller #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        hit,
  input  logic        dirty_bit,
  output logic        cpu_ready,
  output logic        cache_we,
  output logic        mem_in_select,
  output logic        mem_we,
  output logic        mem_re
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_we_q, req_we_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_we_q <= req_we_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_we_d = req_we_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d  = COMPARE;
          req_we_d = cpu_we;
        end
      end
      COMPARE: begin
        // A miss after a refill takes the miss path again, so a faulty
        // datapath can never park the FSM in COMPARE.
        if (hit) begin
          state_d = DONE;
        end else if (dirty_bit) begin
          state_d = WRITEBACK;
          cnt_d   = '0;
        end else begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      WRITEBACK: begin
        if (cnt_q == CNT_LAST) begin
          state_d = REFILL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REFILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    cpu_ready     = 1'b0;
    cache_we      = 1'b0;
    mem_in_select = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    unique case (state_q)
      COMPARE: begin
        // A write hit updates the line in the same cycle as the compare.
        cache_we = hit & req_we_q;
      end
      WRITEBACK: begin
        mem_in_select = 1'b1;
        mem_we        = 1'b1;
      end
      REFILL: begin
        mem_re   = 1'b1;
        // The refilled block is written into the cache only once memory
        // has delivered it, i.e. on the last transfer cycle.
        cache_we = (cnt_q == CNT_LAST);
      end
      DONE: begin
        cpu_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // first_q marks the compare that directly follows request acceptance;
  // compares that follow a refill are not counted again.
  logic        first_q, first_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    first_d    = first_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && cpu_req) begin
      first_d = 1'b1;
    end else if (state_q == COMPARE) begin
      first_d = 1'b0;
      if (first_q) begin
        if (hit) hit_cnt_d  = sat_inc(hit_cnt_q);
        else     miss_cnt_d = sat_inc(miss_cnt_q);
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
//
// Bench for cache_controller with MEM_LATENCY = 4. A transaction-level
// model expands each request into its per-cycle expected output trace
// (compare, optional writeback of L cycles, refill of L cycles, retries,
// completion). The bench then drives random don't-care inputs on cycles
// where the controller must ignore them.
// ---------------------------------------------------------------------------
module tb_cache_controller;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic cpu_req = 1'b0;
  logic cpu_we = 1'b0;
  logic hit = 1'b0;
  logic dirty_bit = 1'b0;
  logic cpu_ready, cache_we, mem_in_select, mem_we, mem_re;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_controller #(.MEM_LATENCY(L)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .hit          (hit),
    .dirty_bit    (dirty_bit),
    .cpu_ready    (cpu_ready),
    .cache_we     (cache_we),
    .mem_in_select(mem_in_select),
    .mem_we       (mem_we),
    .mem_re       (mem_re)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: {cpu_ready, cache_we, mem_in_select, mem_we, mem_re}
  logic [4:0] obs;
  assign obs = {cpu_ready, cache_we, mem_in_select, mem_we, mem_re};

  localparam logic [4:0] O_NONE  = 5'b00000;
  localparam logic [4:0] O_READY = 5'b10000;
  localparam logic [4:0] O_CWE   = 5'b01000;
  localparam logic [4:0] O_WB    = 5'b00110;
  localparam logic [4:0] O_RD    = 5'b00001;
  localparam logic [4:0] O_RDWE  = 5'b01001;

  typedef struct {
    logic       start;
    logic       req;
    logic       we;
    logic       hit;
    logic       dirty;
    logic [4:0] exp;
  } step_t;

  step_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic check_lat(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s latency observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic step_t mk(input logic start, input logic req, input logic we,
                               input logic h, input logic d, input logic [4:0] e);
    step_t s;
    s.start = start; s.req = req; s.we = we; s.hit = h; s.dirty = d; s.exp = e;
    return s;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand one request into its expected cycle trace. nmiss compares miss
  // before the final hit; the first miss uses dirty d0, later ones random.
  task automatic build(input logic we, input int nmiss, input logic d0, input int gap);
    logic d;
    for (int g = 0; g < gap; g++) q.push_back(mk(1'b0, 1'b0, rb(), rb(), rb(), O_NONE));
    q.push_back(mk(1'b1, 1'b1, we, rb(), rb(), O_NONE));
    for (int m = 0; m <= nmiss; m++) begin
      if (m == nmiss) begin
        q.push_back(mk(1'b0, rb(), rb(), 1'b1, rb(), we ? O_CWE : O_NONE));
      end else begin
        d = (m == 0) ? d0 : rb();
        q.push_back(mk(1'b0, rb(), rb(), 1'b0, d, O_NONE));
        if (d) for (int i = 0; i < L; i++) q.push_back(mk(1'b0, rb(), rb(), rb(), rb(), O_WB));
        for (int i = 0; i < L; i++)
          q.push_back(mk(1'b0, rb(), rb(), rb(), rb(), (i == L - 1) ? O_RDWE : O_RD));
      end
    end
    q.push_back(mk(1'b0, rb(), rb(), rb(), rb(), O_READY));
  endtask

  // Play the queued trace one cycle per entry and report the observed
  // latency from request to first cpu_ready (-1 if never seen).
  task automatic play(input string tag, output int lat);
    step_t s;
    int t0;
    lat = -1;
    t0 = -1;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      cyc++;
      cpu_req = s.req; cpu_we = s.we; hit = s.hit; dirty_bit = s.dirty;
      @(negedge clk);
      if (s.start) t0 = cyc;
      if (t0 >= 0 && lat < 0 && cpu_ready === 1'b1) lat = cyc - t0;
      check(tag, obs, s.exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic req, input logic we, input logic h,
                       input logic d, input string tag, input logic [4:0] e);
    @(posedge clk);
    #1;
    cyc++;
    rst_b = rst; cpu_req = req; cpu_we = we; hit = h; dirty_bit = d;
    @(negedge clk);
    check(tag, obs, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold", O_NONE);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_idle", O_NONE);

    // Directed latency checks
    build(1'b0, 0, 1'b0, 0); play("read_hit", lat);   check_lat("read_hit", lat, 2);
    build(1'b1, 0, 1'b0, 1); play("write_hit", lat);  check_lat("write_hit", lat, 2);
    build(1'b0, 1, 1'b0, 0); play("clean_miss", lat); check_lat("clean_miss", lat, L + 3);
    build(1'b1, 1, 1'b1, 0); play("dirty_miss", lat); check_lat("dirty_miss", lat, 2 * L + 3);
`ifdef CACHE_CTRL_STATS_EN
    n_cmp++;
    assert ({hit_cnt, miss_cnt} === {16'd2, 16'd2}) else begin
      n_err++;
      $error("FAIL stats observed=%0d/%0d expected=2/2", hit_cnt, miss_cnt);
    end
`endif

    // Reset in the second refill cycle abandons the transfer
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rst_mid_req", O_NONE);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_cmp", O_NONE);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_rf1", O_RD);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rst_mid_rf2", O_RD);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_mid_after", O_NONE);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_mid_idle", O_NONE);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_mid_idle2", O_NONE);
    build(1'b0, 0, 1'b0, 0); play("post_rst_hit", lat); check_lat("post_rst_hit", lat, 2);

    // Reset wins over request acceptance in IDLE
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rst_prio_req", O_NONE);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_prio_nocmp", O_NONE);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_prio_nordy", O_NONE);

    // Random back-to-back and gapped traffic, including repeated misses
    for (int t = 0; t < 40; t++) begin
      build(rb(), $urandom_range(0, 2), rb(), $urandom_range(0, 2));
      play("random", lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
